// File: rtl/seg7_frame_reader.sv
// seg7_frame_reader
//   Receive side of a seven-segment display bus tap. Active-low gfedcba segment
//   patterns arrive one digit per cycle. Each pattern is decoded back to a hex
//   nibble, NUM_DIGITS in-order digits are collected into one frame, and the frame
//   is offered to a consumer over a valid/ready handshake. The block also flags
//   unknown patterns (frame_err), digits that arrive out of order (seq_err), and
//   digits dropped while a frame is still being held (overrun).
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   COLLECT | collecting digits; cnt_q is the next expected digit index
//   HOLD    | complete frame presented; waiting for frame_ready
module seg7_frame_reader #(
  parameter int NUM_DIGITS = 6,
  parameter int IDX_W      = 3
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  input  logic [6:0]              seg_in,
  input  logic [IDX_W-1:0]        seg_idx,
  input  logic                    seg_valid,
  output logic [4*NUM_DIGITS-1:0] frame_value,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    frame_err,
  output logic                    seq_err,
  output logic                    overrun
);

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // Returns {unknown, nibble}. Unknown patterns (including blank) decode to 0.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b1000000: res = {1'b0, 4'h0};
      7'b1111001: res = {1'b0, 4'h1};
      7'b0100100: res = {1'b0, 4'h2};
      7'b0110000: res = {1'b0, 4'h3};
      7'b0011001: res = {1'b0, 4'h4};
      7'b0010010: res = {1'b0, 4'h5};
      7'b0000010: res = {1'b0, 4'h6};
      7'b1111000: res = {1'b0, 4'h7};
      7'b0000000: res = {1'b0, 4'h8};
      7'b0010000: res = {1'b0, 4'h9};
      7'b0001000: res = {1'b0, 4'hA};
      7'b0000011: res = {1'b0, 4'hB};
      7'b1000110: res = {1'b0, 4'hC};
      7'b0100001: res = {1'b0, 4'hD};
      7'b0000110: res = {1'b0, 4'hE};
      7'b0001110: res = {1'b0, 4'hF};
      default:    res = {1'b1, 4'h0};
    endcase
    return res;
  endfunction

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0]   work_q, work_d;
  logic                      err_acc_q, err_acc_d;
  logic [4*NUM_DIGITS-1:0]   frame_value_q, frame_value_d;
  logic                      frame_err_q, frame_err_d;
  logic                      seq_err_q, seq_err_d;
  logic                      overrun_q, overrun_d;

  logic [3:0]                dec_nibble;
  logic                      dec_unknown;
  logic                      collecting;
  logic                      in_order;
  logic                      out_of_order;
  logic                      restart;
  logic                      frame_done;
  logic [IDX_W-1:0]          wr_slot;
  logic [4*NUM_DIGITS-1:0]   work_ins;

  // Decode the incoming pattern and classify the digit against the expected index.
  always_comb begin
    {dec_unknown, dec_nibble} = decode_seg(seg_in);
    collecting   = (state_q == ST_COLLECT);
    in_order     = collecting && seg_valid && (seg_idx == cnt_q);
    out_of_order = collecting && seg_valid && (seg_idx != cnt_q);
    restart      = out_of_order && (seg_idx == '0);
    frame_done   = in_order && (cnt_q == LAST_IDX);
    // A restarting digit always lands in slot 0, an in-order one at cnt_q.
    wr_slot      = in_order ? cnt_q : '0;
  end

  // Work buffer with the current digit merged in; also the source of a completed frame.
  always_comb begin
    work_ins = work_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (wr_slot == IDX_W'(i)) begin
        work_ins[4*i +: 4] = dec_nibble;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (frame_done)  state_d = ST_HOLD;
      ST_HOLD:    if (frame_ready) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  // FSM output logic: a frame is offered exactly while held.
  always_comb begin
    frame_valid = (state_q == ST_HOLD);
  end

  // Datapath next-values: digit counter, work buffer, error accumulation, frame load.
  always_comb begin
    cnt_d         = cnt_q;
    work_d        = work_q;
    err_acc_d     = err_acc_q;
    frame_value_d = frame_value_q;
    frame_err_d   = frame_err_q;
    seq_err_d     = out_of_order;
    // Any digit seen while holding is dropped, even if the frame is accepted on
    // the same edge; it never becomes part of the next frame.
    overrun_d     = seg_valid && (state_q == ST_HOLD);

    if (in_order) begin
      work_d = work_ins;
      if (frame_done) begin
        frame_value_d = work_ins;
        frame_err_d   = err_acc_q | dec_unknown;
        cnt_d         = '0;
        err_acc_d     = 1'b0;
      end else begin
        cnt_d     = cnt_q + IDX_ONE;
        err_acc_d = err_acc_q | dec_unknown;
      end
    end else if (out_of_order) begin
      // Partial frame is discarded; a digit 0 starts a fresh frame right away.
      if (restart) begin
        work_d    = work_ins;
        cnt_d     = IDX_ONE;
        err_acc_d = dec_unknown;
      end else begin
        cnt_d     = '0;
        err_acc_d = 1'b0;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      cnt_q         <= '0;
      work_q        <= '0;
      err_acc_q     <= 1'b0;
      frame_value_q <= '0;
      frame_err_q   <= 1'b0;
      seq_err_q     <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      work_q        <= work_d;
      err_acc_q     <= err_acc_d;
      frame_value_q <= frame_value_d;
      frame_err_q   <= frame_err_d;
      seq_err_q     <= seq_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign frame_value = frame_value_q;
  assign frame_err   = frame_err_q;
  assign seq_err     = seq_err_q;
  assign overrun     = overrun_q;

endmodule
